// File: rtl/register_bank.sv
// 32-entry MIPS register file: two combinational read ports, one write port, power-up clear, debug dump stream.
// Optional same-cycle write-to-read bypass is enabled by defining REGBANK_WRITE_BYPASS_EN.
module register_bank #(
  parameter int len   = 32,
  parameter int depth = 32,
  parameter int NB    = $clog2(depth)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NB-1:0]   rs,
  input  logic [NB-1:0]   rt,
  output logic [len-1:0]  read_data_a,
  output logic [len-1:0]  read_data_b,
  input  logic            register_write,
  input  logic [NB-1:0]   rd_write,
  input  logic [len-1:0]  write_data,
  output logic            init_done,
  input  logic            dump_start,
  input  logic            dump_ready,
  output logic            dump_valid,
  output logic [NB-1:0]   dump_addr,
  output logic [len-1:0]  dump_data,
  output logic            dump_last
);

  typedef enum logic [1:0] {INIT, IDLE, DUMP} state_t;

  localparam logic [NB-1:0] LAST_ADDR = NB'(depth - 1);

  state_t          state_reg, state_next;
  logic [NB-1:0]   clr_ptr_reg, clr_ptr_next;
  logic [NB-1:0]   dump_ptr_reg, dump_ptr_next;
  logic [len-1:0]  mem [depth];
  logic            wr_en;
  logic [NB-1:0]   raddr [2];
  logic [len-1:0]  rdata [2];
  logic [1:0]      hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= INIT;
      clr_ptr_reg  <= '0;
      dump_ptr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_ptr_reg  <= clr_ptr_next;
      dump_ptr_reg <= dump_ptr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_ptr_next  = clr_ptr_reg;
    dump_ptr_next = dump_ptr_reg;
    case (state_reg)
      INIT: begin
        clr_ptr_next = clr_ptr_reg + NB'(1);
        if (clr_ptr_reg == LAST_ADDR) begin
          state_next   = IDLE;
          clr_ptr_next = '0;
        end
      end
      IDLE: begin
        if (dump_start) begin
          state_next    = DUMP;
          dump_ptr_next = '0;
        end
      end
      DUMP: begin
        if (dump_ready) begin
          if (dump_ptr_reg == LAST_ADDR) begin
            state_next    = IDLE;
            dump_ptr_next = '0;
          end else begin
            dump_ptr_next = dump_ptr_reg + NB'(1);
          end
        end
      end
      default: state_next = INIT;
    endcase
  end

  assign wr_en = register_write && (rd_write != '0) && (state_reg != INIT) && !reset;

  // The clear sequencer owns the write port while INIT is active.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_reg == INIT)
        mem[clr_ptr_reg] <= '0;
      else if (wr_en)
        mem[rd_write] <= write_data;
    end
  end

  assign raddr[0] = rs;
  assign raddr[1] = rt;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
`ifdef REGBANK_WRITE_BYPASS_EN
      assign hit[gi] = wr_en && (rd_write == raddr[gi]);
`else
      assign hit[gi] = 1'b0;
`endif
      assign rdata[gi] = ((state_reg == INIT) || (raddr[gi] == '0)) ? '0 :
                         hit[gi] ? write_data : mem[raddr[gi]];
    end
  endgenerate

  assign read_data_a = rdata[0];
  assign read_data_b = rdata[1];

  assign init_done  = (state_reg != INIT);
  assign dump_valid = (state_reg == DUMP);
  assign dump_addr  = dump_ptr_reg;
  assign dump_last  = (state_reg == DUMP) && (dump_ptr_reg == LAST_ADDR);
  // A held beat re-reads the array every cycle, so a write to its address shows up.
  assign dump_data  = ((state_reg == DUMP) && (dump_ptr_reg != '0)) ? mem[dump_ptr_reg] : '0;

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: random reads/writes and dump streams against an array model.
module tb_register_bank;
  localparam int LEN   = 32;
  localparam int DEPTH = 32;
  localparam int NB    = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [NB-1:0]   rs, rt, rd_write, dump_addr;
  logic [LEN-1:0]  read_data_a, read_data_b, write_data, dump_data;
  logic            register_write, init_done, dump_start, dump_ready, dump_valid, dump_last;

  int compared = 0;
  int mismatched = 0;

  logic [LEN-1:0] ref_mem [DEPTH];
  int init_left;

  register_bank #(.len(LEN), .depth(DEPTH), .NB(NB)) dut (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt),
    .read_data_a(read_data_a), .read_data_b(read_data_b),
    .register_write(register_write), .rd_write(rd_write), .write_data(write_data),
    .init_done(init_done), .dump_start(dump_start), .dump_ready(dump_ready),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data), .dump_last(dump_last)
  );

  always #5 clk = ~clk;

  // Model: reset empties the file and opens a DEPTH-cycle window where everything reads 0 and writes are lost.
  task automatic tick();
    if (reset) begin
      init_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else begin
      if (init_left == 0 && register_write && rd_write != 0) ref_mem[rd_write] = write_data;
      if (init_left > 0) init_left--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [LEN-1:0] exp_read(input logic [NB-1:0] addr);
    if (init_left > 0 || addr == 0) return '0;
`ifdef REGBANK_WRITE_BYPASS_EN
    if (register_write && rd_write != 0 && rd_write == addr) return write_data;
`endif
    return ref_mem[addr];
  endfunction

  function automatic logic [LEN-1:0] exp_dump(input int beat);
    return (beat == 0) ? '0 : ref_mem[beat];
  endfunction

  task automatic start_dump();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    settle();
    compared++; if (init_done !== 1'b0) begin mismatched++; $display("FAIL reset_init_done got=%b want=0", init_done); end
    compared++; if (dump_valid !== 1'b0) begin mismatched++; $display("FAIL reset_dump_valid got=%b want=0", dump_valid); end
    compared++; if (dump_last !== 1'b0) begin mismatched++; $display("FAIL reset_dump_last got=%b want=0", dump_last); end
    compared++; if (dump_addr !== '0) begin mismatched++; $display("FAIL reset_dump_addr got=%0d want=0", dump_addr); end
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rs = 5;
      register_write = (i == 3);
      rd_write = 5;
      write_data = 32'h0000AAAA;
      dump_start = (i == 6);
      settle();
      compared++; if (init_done !== 1'b0) begin mismatched++; $display("FAIL init_done_low cyc=%0d got=%b want=0", i, init_done); end
      compared++; if (read_data_a !== 32'h0) begin mismatched++; $display("FAIL init_read cyc=%0d got=%h want=0", i, read_data_a); end
      tick();
    end
    register_write = 1'b0;
    dump_start = 1'b0;
    settle();
    compared++; if (init_done !== 1'b1) begin mismatched++; $display("FAIL init_done_high got=%b want=1", init_done); end
    compared++; if (read_data_a !== exp_read(5)) begin mismatched++; $display("FAIL init_write_dropped got=%h want=%h", read_data_a, exp_read(5)); end
    compared++; if (dump_valid !== 1'b0) begin mismatched++; $display("FAIL init_dump_start_ignored got=%b want=0", dump_valid); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    register_write = 1'b1; rd_write = 3; write_data = 32'h12345678;
    tick();
    register_write = 1'b0; rs = 3;
    settle();
    compared++; if (read_data_a !== 32'h12345678) begin mismatched++; $display("FAIL write_r3 got=%h want=12345678", read_data_a); end
    register_write = 1'b1; rd_write = 0; write_data = 32'hFFFFFFFF;
    tick();
    register_write = 1'b0; rt = 0;
    settle();
    compared++; if (read_data_b !== 32'h0) begin mismatched++; $display("FAIL write_r0_dropped got=%h want=0", read_data_b); end
    $display("test_basic done");
  endtask

  task automatic test_bypass();
    register_write = 1'b1; rd_write = 7; write_data = 32'hDEADBEEF; rs = 7; rt = 7;
    settle();
    compared++; if (read_data_a !== exp_read(7)) begin mismatched++; $display("FAIL bypass_a got=%h want=%h", read_data_a, exp_read(7)); end
    compared++; if (read_data_b !== exp_read(7)) begin mismatched++; $display("FAIL bypass_b got=%h want=%h", read_data_b, exp_read(7)); end
    tick();
    register_write = 1'b0;
    settle();
    compared++; if (read_data_a !== 32'hDEADBEEF) begin mismatched++; $display("FAIL bypass_after got=%h want=deadbeef", read_data_a); end
    $display("test_bypass done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      register_write = 1'($urandom);
      rd_write = NB'($urandom);
      write_data = $urandom;
      rs = ($urandom_range(0, 3) == 0) ? rd_write : NB'($urandom);
      rt = ($urandom_range(0, 3) == 0) ? rd_write : NB'($urandom);
      settle();
      compared++; if (read_data_a !== exp_read(rs)) begin mismatched++; $display("FAIL rand_a i=%0d rs=%0d got=%h want=%h", i, rs, read_data_a, exp_read(rs)); end
      compared++; if (read_data_b !== exp_read(rt)) begin mismatched++; $display("FAIL rand_b i=%0d rt=%0d got=%h want=%h", i, rt, read_data_b, exp_read(rt)); end
      tick();
    end
    register_write = 1'b0;
    $display("test_random done");
  endtask

  task automatic test_dump();
    for (int i = 1; i < DEPTH; i++) begin
      register_write = 1'b1; rd_write = NB'(i); write_data = 32'(i * 17);
      tick();
    end
    register_write = 1'b0;
    start_dump();
    dump_ready = 1'b1;
    for (int b = 0; b < DEPTH; b++) begin
      dump_start = (b == 5);
      settle();
      compared++; if (dump_valid !== 1'b1) begin mismatched++; $display("FAIL dump_valid beat=%0d got=%b want=1", b, dump_valid); end
      compared++; if (dump_addr !== NB'(b)) begin mismatched++; $display("FAIL dump_addr beat=%0d got=%0d want=%0d", b, dump_addr, b); end
      compared++; if (dump_data !== 32'(b * 17)) begin mismatched++; $display("FAIL dump_data beat=%0d got=%h want=%h", b, dump_data, 32'(b * 17)); end
      compared++; if (dump_last !== (b == DEPTH - 1)) begin mismatched++; $display("FAIL dump_last beat=%0d got=%b", b, dump_last); end
      tick();
    end
    dump_start = 1'b0;
    settle();
    compared++; if (dump_valid !== 1'b0) begin mismatched++; $display("FAIL dump_end_valid got=%b want=0", dump_valid); end
    compared++; if (dump_last !== 1'b0) begin mismatched++; $display("FAIL dump_end_last got=%b want=0", dump_last); end
    $display("test_dump done");
  endtask

  task automatic test_dump_hold();
    start_dump();
    dump_ready = 1'b1;
    for (int b = 0; b < 4; b++) tick();
    dump_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      register_write = (k == 1); rd_write = 4; write_data = 32'h55;
      settle();
      compared++; if (dump_addr !== NB'(4)) begin mismatched++; $display("FAIL hold_addr k=%0d got=%0d want=4", k, dump_addr); end
      compared++; if (dump_data !== exp_dump(4)) begin mismatched++; $display("FAIL hold_data k=%0d got=%h want=%h", k, dump_data, exp_dump(4)); end
      tick();
    end
    register_write = 1'b0;
    settle();
    compared++; if (dump_data !== 32'h55) begin mismatched++; $display("FAIL hold_new_value got=%h want=55", dump_data); end
    dump_ready = 1'b1;
    tick();
    settle();
    compared++; if (dump_addr !== NB'(5)) begin mismatched++; $display("FAIL hold_release_addr got=%0d want=5", dump_addr); end
    for (int b = 5; b < DEPTH; b++) tick();
    settle();
    compared++; if (dump_valid !== 1'b0) begin mismatched++; $display("FAIL hold_end_valid got=%b want=0", dump_valid); end
    $display("test_dump_hold done");
  endtask

  task automatic test_dump_random();
    int beat = 0;
    int cyc = 0;
    start_dump();
    while (beat < DEPTH && cyc < 400) begin
      dump_ready = 1'($urandom);
      register_write = 1'($urandom);
      rd_write = ($urandom_range(0, 2) == 0) ? NB'(beat) : NB'($urandom);
      write_data = $urandom;
      settle();
      compared++; if (dump_valid !== 1'b1) begin mismatched++; $display("FAIL rdump_valid cyc=%0d got=%b want=1", cyc, dump_valid); end
      compared++; if (dump_addr !== NB'(beat)) begin mismatched++; $display("FAIL rdump_addr cyc=%0d got=%0d want=%0d", cyc, dump_addr, beat); end
      compared++; if (dump_data !== exp_dump(beat)) begin mismatched++; $display("FAIL rdump_data cyc=%0d got=%h want=%h", cyc, dump_data, exp_dump(beat)); end
      compared++; if (dump_last !== (beat == DEPTH - 1)) begin mismatched++; $display("FAIL rdump_last cyc=%0d got=%b", cyc, dump_last); end
      if (dump_ready) beat++;
      tick();
      cyc++;
    end
    register_write = 1'b0;
    dump_ready = 1'b1;
    compared++; if (beat != DEPTH) begin mismatched++; $display("FAIL rdump_timeout got=%0d beats want=%0d", beat, DEPTH); end
    settle();
    compared++; if (dump_valid !== 1'b0) begin mismatched++; $display("FAIL rdump_end_valid got=%b want=0", dump_valid); end
    $display("test_dump_random done");
  endtask

  task automatic test_reset_mid();
    start_dump();
    dump_ready = 1'b1;
    for (int b = 0; b < 10; b++) tick();
    settle();
    compared++; if (dump_addr !== NB'(10)) begin mismatched++; $display("FAIL mid_addr got=%0d want=10", dump_addr); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    compared++; if (dump_valid !== 1'b0) begin mismatched++; $display("FAIL mid_valid got=%b want=0", dump_valid); end
    compared++; if (init_done !== 1'b0) begin mismatched++; $display("FAIL mid_init_done got=%b want=0", init_done); end
    for (int i = 0; i < DEPTH - 1; i++) tick();
    settle();
    compared++; if (init_done !== 1'b0) begin mismatched++; $display("FAIL mid_init_last got=%b want=0", init_done); end
    tick();
    settle();
    compared++; if (init_done !== 1'b1) begin mismatched++; $display("FAIL mid_init_done_high got=%b want=1", init_done); end
    for (int i = 0; i < DEPTH; i++) begin
      rs = NB'(i); rt = NB'(DEPTH - 1 - i);
      settle();
      compared++; if (read_data_a !== 32'h0) begin mismatched++; $display("FAIL mid_clear_a r=%0d got=%h want=0", i, read_data_a); end
      compared++; if (read_data_b !== exp_read(rt)) begin mismatched++; $display("FAIL mid_clear_b r=%0d got=%h want=%h", rt, read_data_b, exp_read(rt)); end
      tick();
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    reset = 1'b1; rs = '0; rt = '0; rd_write = '0; write_data = '0;
    register_write = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
    init_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    test_reset();
    test_basic();
    test_bypass();
    test_random();
    test_dump();
    test_dump_hold();
    test_dump_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- 32-entry general-purpose register file for the 5-stage MIPS pipeline. Sits at the decode stage.
- Two read ports feed the ID/EX latch. One write port is driven by write-back.
- Producer side for the values the forwarding logic bypasses: same-cycle write-to-read bypass covers the WB/ID overlap that EX forwarding does not.
- Includes a power-up clear sequencer and a handshaked dump port for the debug unit, which streams all registers out.

Parameters:
- len, 32, data width of each register.
- depth, 32, number of registers.
- NB, $clog2(depth), register address width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- rs  in  NB  read address, port A.
- rt  in  NB  read address, port B.
- read_data_a  out  len  contents of register rs (combinational).
- read_data_b  out  len  contents of register rt (combinational).
- register_write  in  1  write enable from write-back.
- rd_write  in  NB  write address.
- write_data  in  len  write data.
- init_done  out  1  high once the clear sequence has finished.
- dump_start  in  1  single-cycle request to stream all registers.
- dump_ready  in  1  consumer accepts the current beat.
- dump_valid  out  1  current beat valid.
- dump_addr  out  NB  index of the current beat.
- dump_data  out  len  register value of the current beat.
- dump_last  out  1  high on the beat with dump_addr == depth-1.

Behaviour:

Reset:
- The FSM is one of INIT, IDLE, DUMP. Reset forces INIT, clear pointer 0, dump pointer 0.
- Reset values: init_done=0, dump_valid=0, dump_last=0, dump_addr=0.

INIT:
- Clears one register per cycle at the pointer, then increments the pointer.
- After register depth-1 is cleared, goes to IDLE; init_done=1 from the next cycle. This is exactly depth cycles after reset deasserts.
- In INIT: read_data_a/b=0, writes ignored, dump_start ignored (not latched).

Reads:
- read_data_x = array[addr], except address 0, which always returns 0.

Writes:
- On the rising edge, when register_write=1, rd_write!=0 and state!=INIT: array[rd_write] <= write_data.
- A write to register 0 is silently dropped.

IDLE:
- dump_start=1 selects DUMP, dump pointer 0.

DUMP:
- dump_valid=1, dump_addr=pointer, dump_data=array[pointer] (register 0 reads as 0), dump_last=(pointer==depth-1).
- On dump_valid & dump_ready, the pointer increments.
- The beat with dump_last accepted returns to IDLE; dump_valid=0 the next cycle.
- dump_ready=0 holds the beat stable. dump_addr and dump_data may change only if a write hits the held address, and dump_data then shows the new value.
- dump_start while in DUMP is ignored. Normal reads and writes continue during DUMP.
- A dump takes at least depth cycles.

Reset mid-operation:
- Reset in any state returns to INIT on that edge, clearing dump_valid.
- The clear sequence restarts from 0, so the whole array is re-zeroed.

Simultaneous events:
- Write and read of the same address in the same cycle: see Optional Feature.
- Write and dump beat on the same address: the beat shows the pre-edge value, or the new value if the beat is held.

Optional Feature:
- Macro: REGBANK_WRITE_BYPASS_EN.
- Defined: when register_write=1, rd_write!=0, state!=INIT and rs (or rt) == rd_write, read_data_a (or read_data_b) = write_data in the same cycle. This is the write-before-read behaviour the pipeline needs when WB and ID target the same register.
- Undefined: read ports return the stored array value. The new value is visible from the cycle after the write edge.

Test Plan:
- Release reset, hold all inputs at 0 → init_done=0 for 32 cycles, 1 on cycle 33. Read rs=5 → 0. A write during INIT (rd_write=5, data 0xAAAA) is not stored.
- After init: write rd_write=3 data 0x12345678, then rs=3 on the next cycle → read_data_a=0x12345678. Write rd_write=0 data 0xFFFFFFFF, then rt=0 → 0.
- Same cycle register_write=1, rd_write=7, write_data=0xDEADBEEF, rs=7. With REGBANK_WRITE_BYPASS_EN → 0xDEADBEEF. Without → old value 0; 0xDEADBEEF appears the next cycle.
- Preload r1..r31 = index*0x11, pulse dump_start, dump_ready=1 → 32 consecutive beats with dump_addr 0..31 and data 0, 0x11, …, 0x20F. dump_last only on addr 31; dump_valid=0 afterwards.
- During a dump, hold dump_ready=0 at addr 4 for 3 cycles → beat stable. Write r4=0x55 while held → dump_data=0x55. Release → continues at addr 5.
- Assert reset at dump beat 10 → dump_valid=0 next cycle, INIT re-runs 32 cycles, all registers then read 0.
